// File: rtl/div_pkg.sv
// Shared encodings for the RV32M divider: operation codes, FSM states and op decoding helpers.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Bit 0 clear selects the signed variants, bit 1 set selects the remainder result.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;
    logic          q_bit;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};

    // Subtraction as rem_sh + ~divisor + 1 with one guard bit; its MSB is the borrow.
    n_b_add #(
        .N(XLEN + 1)
    ) u_sub (
        .a_i  (rem_sh),
        .b_i  (~{1'b0, divisor_i}),
        .cin_i(1'b1),
        .sum_o(trial)
    );

    assign q_bit = ~trial[XLEN];
    // When the trial succeeds the difference is below the divisor; otherwise rem_sh is, so both fit XLEN bits.
    assign rem_o = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], q_bit};

endmodule

// File: rtl/n_b_add.sv
// Generic N-bit adder with carry-in; the sum wraps modulo 2^N.
module n_b_add #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i + {{(N-1){1'b0}}, cin_i};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): magnitude restoring division, then sign fix.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   step_rem, step_quo;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic              sgn;

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign sgn = op_is_signed(op);

    always_comb begin
        quo_fix = neg_quo_q ? negate(quo_q) : quo_q;
        rem_fix = neg_rem_q ? negate(rem_q) : rem_q;
        // Special cases override whatever the iterations produced.
        if (div0_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf_q) begin
            quo_fix = INT_MIN;
            rem_fix = '0;
        end
    end

    always_comb begin
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        a_d       = a_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    neg_quo_d = sgn & (a[XLEN-1] ^ b[XLEN-1]);
                    neg_rem_d = sgn & a[XLEN-1];
                    div0_d    = (b == '0);
                    ovf_d     = sgn & (a == INT_MIN) & (b == '1);
                    a_d       = a;
                    quo_d     = (sgn && a[XLEN-1]) ? negate(a) : a;
                    divisor_d = (sgn && b[XLEN-1]) ? negate(b) : b;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(XLEN - 1);
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
            end
            S_FIX: begin
                result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            a_q       <= a_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, busy window, signed/unsigned results, special cases, abort.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    localparam int LAT = 34;

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op and waits (bounded) for done; lat counts cycles after the start cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_low, output logic [31:0] res);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_low = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_low++;
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
    endtask

    task automatic test_vectors();
        logic [1:0]  vop [12];
        logic [31:0] va  [12];
        logic [31:0] vb  [12];
        logic [31:0] vex [12];
        int lat, bl;
        logic [31:0] res;
        // DIVU/REMU basic, signed quotient/remainder signs, divide by zero, signed overflow, unsigned extremes.
        vop[0]  = 2'b01; va[0]  = 32'd100;        vb[0]  = 32'd7;          vex[0]  = 32'd14;
        vop[1]  = 2'b11; va[1]  = 32'd100;        vb[1]  = 32'd7;          vex[1]  = 32'd2;
        vop[2]  = 2'b10; va[2]  = 32'hFFFFFFF9;   vb[2]  = 32'd2;          vex[2]  = 32'hFFFFFFFF;
        vop[3]  = 2'b00; va[3]  = 32'hFFFFFFF9;   vb[3]  = 32'd2;          vex[3]  = 32'hFFFFFFFD;
        vop[4]  = 2'b00; va[4]  = 32'hFFFFFF9C;   vb[4]  = 32'd7;          vex[4]  = 32'hFFFFFFF2;
        vop[5]  = 2'b10; va[5]  = 32'd7;          vb[5]  = 32'hFFFFFFFE;   vex[5]  = 32'd1;
        vop[6]  = 2'b00; va[6]  = 32'd5;          vb[6]  = 32'd0;          vex[6]  = 32'hFFFFFFFF;
        vop[7]  = 2'b11; va[7]  = 32'd5;          vb[7]  = 32'd0;          vex[7]  = 32'd5;
        vop[8]  = 2'b10; va[8]  = 32'hFFFFFFFB;   vb[8]  = 32'd0;          vex[8]  = 32'hFFFFFFFB;
        vop[9]  = 2'b00; va[9]  = 32'h80000000;   vb[9]  = 32'hFFFFFFFF;   vex[9]  = 32'h80000000;
        vop[10] = 2'b10; va[10] = 32'h80000000;   vb[10] = 32'hFFFFFFFF;   vex[10] = 32'h0;
        vop[11] = 2'b11; va[11] = 32'h80000000;   vb[11] = 32'hFFFFFFFF;   vex[11] = 32'h80000000;
        for (int i = 0; i < 12; i++) begin
            run_op(vop[i], va[i], vb[i], lat, bl, res);
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL vec%0d_latency: got %0d cycles, required %0d", i, lat, LAT);
            end
            checks++;
            if (bl != 0) begin
                failures++;
                $display("FAIL vec%0d_busy: busy low in %0d cycles, required 0", i, bl);
            end
            checks++;
            if (res !== vex[i]) begin
                failures++;
                $display("FAIL vec%0d_result: got %h, required %h", i, res, vex[i]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== vex[i]) begin
                failures++;
                $display("FAIL vec%0d_after_done: busy=%b done=%b result=%h, required 0 0 %h",
                         i, busy, done, result, vex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bl;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 5) begin
                start = 1'b1; op = 2'b00; a = 32'd77; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat != LAT || result !== 32'd100) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d result=%h, required %0d %h", lat, result, LAT, 32'd100);
        end
        // run_op raises start at the next negedge, i.e. in the IDLE cycle right after DONE.
        run_op(2'b11, 32'd77, 32'd3, lat, bl, res);
        checks++;
        if (lat != LAT || bl != 0 || res !== 32'd2) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d busy_low=%0d result=%h, required %0d 0 %h", lat, bl, res, LAT, 32'd2);
        end
    endtask

    task automatic test_abort();
        int lat, bl, extra_done;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        extra_done = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) extra_done++;
            @(negedge clk);
        end
        checks++;
        if (extra_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", extra_done);
        end
        run_op(2'b11, 32'd100, 32'd7, lat, bl, res);
        checks++;
        if (lat != LAT || bl != 0 || res !== 32'd2) begin
            failures++;
            $display("FAIL abort_recover: lat=%0d busy_low=%0d result=%h, required %0d 0 %h", lat, bl, res, LAT, 32'd2);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
